prospect_car_detector: RTL

// - Upstream stage of the Stoplight controller; drives its car_present input.
// - Synchronises and debounces the raw Prospect inductive-loop sensor.
// - Latches a call until Prospect is served (light_pros == GRN), then re-arms once Prospect returns to RED.
// - Flags a sensor stuck active for too long.

---
 rtl/prospect_car_detector_pkg.sv | 14 +
 rtl/prospect_car_detector_sync_debounce.sv | 49 ++++
 rtl/prospect_car_detector.sv | 103 ++++++++++
 3 files changed

// File: rtl/prospect_car_detector_pkg.sv
// Shared encodings for the Prospect car detector: light codes and detector FSM states.
package prospect_car_detector_pkg;

   localparam logic [2:0] GRN = 3'b100;
   localparam logic [2:0] YLW = 3'b010;
   localparam logic [2:0] RED = 3'b001;

   typedef enum logic [1:0] {
      DET_IDLE  = 2'd0,
      DET_CALL  = 2'd1,
      DET_SERVE = 2'd2
   } det_state_t;

endpackage

// File: rtl/prospect_car_detector_sync_debounce.sv
// Two-flop synchroniser, run-length debounce and a one-cycle pulse that follows each
// debounced rise (rise is high in the first cycle that dout is high).
module sync_debounce
#(
   parameter int DEBOUNCE_CYC = 2
)(
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic rise
);

   localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic             r_meta;
   logic             r_sync;
   logic             r_deb;
   logic             r_rise;
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_deb  <= 1'b0;
         r_rise <= 1'b0;
         r_cnt  <= '0;
      end else begin
         r_meta <= din;
         r_sync <= r_meta;
         r_rise <= 1'b0;
         if (r_sync == r_deb) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_deb  <= r_sync;
            r_cnt  <= '0;
            r_rise <= r_sync;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign dout = r_deb;
   assign rise = r_rise;

endmodule

// File: rtl/prospect_car_detector.sv
// Prospect loop detector: debounced call latch toward Stoplight plus stuck-sensor flag.
// Optional saturating car counter enabled by defining CAR_COUNT_EN.
module prospect_car_detector
   import prospect_car_detector_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 2,
   parameter int STUCK_CYC    = 24
`ifdef CAR_COUNT_EN
 , parameter int COUNT_W      = 8
`endif
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               loop_raw,
   input  logic [2:0]         light_pros,
   output logic               car_present,
   output logic               sensor_fault
`ifdef CAR_COUNT_EN
 , output logic [COUNT_W-1:0] car_count
`endif
);

   localparam int SCNT_W = $clog2(STUCK_CYC + 1);
   localparam logic [SCNT_W-1:0] SCNT_MAX = SCNT_W'(STUCK_CYC);

   logic              w_deb;
   logic              w_rise;
   logic              w_light_legal;
   det_state_t        w_state_next;
   det_state_t        r_state;
   logic              r_car_present;
   logic              r_fault;
   logic [SCNT_W-1:0] r_scnt;

   sync_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_sync_debounce (
      .clk  (clk),
      .rst  (rst),
      .din  (loop_raw),
      .dout (w_deb),
      .rise (w_rise)
   );

   assign w_light_legal = (light_pros == GRN) || (light_pros == YLW) || (light_pros == RED);

   // A corrupted (non one-hot) light code freezes the FSM rather than guessing.
   always_comb begin
      w_state_next = r_state;
      if (w_light_legal) begin
         case (r_state)
            DET_IDLE:  if (w_deb && (light_pros != GRN)) w_state_next = DET_CALL;
            DET_CALL:  if (light_pros == GRN)            w_state_next = DET_SERVE;
            DET_SERVE: if (light_pros == RED)            w_state_next = DET_IDLE;
            default:                                     w_state_next = DET_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= DET_IDLE;
         r_car_present <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_car_present <= (w_state_next == DET_CALL);
      end
   end

   // Fault is gated by the live debounced level so it drops on the edge after deb falls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_scnt  <= '0;
         r_fault <= 1'b0;
      end else begin
         r_fault <= w_deb && (r_scnt == SCNT_MAX);
         if (!w_deb) begin
            r_scnt <= '0;
         end else if (r_scnt != SCNT_MAX) begin
            r_scnt <= r_scnt + 1'b1;
         end
      end
   end

   assign car_present  = r_car_present;
   assign sensor_fault = r_fault;

`ifdef CAR_COUNT_EN
   logic [COUNT_W-1:0] r_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (w_rise && (r_count != '1)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign car_count = r_count;
`else
   logic w_unused_rise;
   assign w_unused_rise = w_rise;
`endif

endmodule
